// File: rtl/board_row_fetcher_if.sv
// board_row_fetcher_if: row-load request, board-memory read port and committed-row bus.
interface board_row_fetcher_if #(
  parameter int BOARD_COLS = 10,
  parameter int CELL_W = 16,
  parameter int ADDR_W = 8
);
  logic LD_Row;
  logic [7:0] rowNum;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_rd;
  logic [CELL_W-1:0] mem_rdata;
  logic [CELL_W-1:0] Row [BOARD_COLS];
  logic rowReady;
  logic busy;
  modport slave (input LD_Row, rowNum, mem_rdata, output mem_addr, mem_rd, Row, rowReady, busy);
  modport master (output LD_Row, rowNum, mem_rdata, input mem_addr, mem_rd, Row, rowReady, busy);
endinterface

// File: rtl/board_row_fetcher.sv
// board_row_fetcher: fetches one board row cell-by-cell into a shadow buffer, then commits it atomically.
// BLANK_OOR_EN: out-of-range rows commit an all-zero row without reading memory (else clamped to the last row).
module board_row_fetcher #(
  parameter int BOARD_ROWS = 20,
  parameter int BOARD_COLS = 10,
  parameter int CELL_W = 16,
  parameter int ADDR_W = 8
) (
  input logic Clk,
  input logic reset,
  board_row_fetcher_if.slave bus
);
  localparam int COL_W = $clog2(BOARD_COLS + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, COMMIT} state_e;
  state_e state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, cap_col_q;
  logic [ADDR_W-1:0] base_q, base_d;
  logic ld_q, rd_q, accept, oor;
  logic [7:0] row_sel;
  logic [CELL_W-1:0] shadow_q [BOARD_COLS];
  logic [CELL_W-1:0] row_q [BOARD_COLS];
  logic [CELL_W-1:0] row_d [BOARD_COLS];
  always_comb begin
    accept = state_q == IDLE && bus.LD_Row && !ld_q;
    oor = 32'(bus.rowNum) >= BOARD_ROWS;
    row_sel = oor ? 8'(BOARD_ROWS - 1) : bus.rowNum;
    state_d = state_q;
    col_d = col_q;
    base_d = base_q;
    case (state_q)
      IDLE: if (accept) begin
`ifdef BLANK_OOR_EN
        state_d = oor ? COMMIT : READ;
`else
        state_d = READ;
`endif
        col_d = '0;
        base_d = ADDR_W'(32'(row_sel) * BOARD_COLS);
      end
      READ: begin
        col_d = col_q + COL_W'(1);
        state_d = col_q == COL_W'(BOARD_COLS - 1) ? DRAIN : READ;
      end
      DRAIN: state_d = COMMIT;
      default: state_d = IDLE;
    endcase
    // The last cell arrives during DRAIN, so it bypasses the shadow into the committed row.
    for (int i = 0; i < BOARD_COLS; i++) begin
      row_d[i] = row_q[i];
      if (state_q == DRAIN) row_d[i] = (rd_q && cap_col_q == COL_W'(i)) ? bus.mem_rdata : shadow_q[i];
`ifdef BLANK_OOR_EN
      if (accept && oor) row_d[i] = '0;
`endif
    end
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q <= '0;
      base_q <= '0;
      ld_q <= 1'b0;
      rd_q <= 1'b0;
      cap_col_q <= '0;
      shadow_q <= '{default: '0};
      row_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      base_q <= base_d;
      ld_q <= bus.LD_Row;
      rd_q <= state_q == READ;
      cap_col_q <= col_q;
      if (rd_q) shadow_q[cap_col_q] <= bus.mem_rdata;
      row_q <= row_d;
    end
  end
  assign bus.mem_rd = state_q == READ;
  assign bus.mem_addr = bus.mem_rd ? base_q + ADDR_W'(col_q) : '0;
  assign bus.rowReady = state_q == COMMIT;
  assign bus.busy = state_q != IDLE;
  assign bus.Row = row_q;
endmodule

// File: tb/tb_board_row_fetcher.sv
// tb_board_row_fetcher: directed fetches with a scoreboard of expected addresses and committed rows.
module tb_board_row_fetcher;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int CW = 16;
  localparam int AW = 8;
  localparam int RW = COLS * CW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;
  int aq_addr[$], aq_cyc[$], cq_cyc[$];
  logic [RW-1:0] cq_row[$];
  board_row_fetcher_if #(.BOARD_COLS(COLS), .CELL_W(CW), .ADDR_W(AW)) bus ();
  board_row_fetcher #(.BOARD_ROWS(ROWS), .BOARD_COLS(COLS), .CELL_W(CW), .ADDR_W(AW)) dut (
    .Clk(clk),
    .reset(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Board memory: cell k holds 16'h0100+k, one-cycle read latency.
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? CW'(16'h0100 + int'(bus.mem_addr)) : '0;
  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  function automatic logic [RW-1:0] exp_row(input int r);
    logic [RW-1:0] v;
    for (int i = 0; i < COLS; i++) v[i*CW +: CW] = CW'(16'h0100 + r * COLS + i);
    return v;
  endfunction
  function automatic logic [RW-1:0] cur_row();
    logic [RW-1:0] v;
    for (int i = 0; i < COLS; i++) v[i*CW +: CW] = bus.Row[i];
    return v;
  endfunction
  task automatic expect_fetch(input int r, input int n, input int cnt);
    int eff;
    eff = r >= ROWS ? ROWS - 1 : r;
    for (int i = 0; i < cnt; i++) begin
      aq_addr.push_back(eff * COLS + i);
      aq_cyc.push_back(n + 1 + i);
    end
    if (cnt == COLS) begin
      cq_row.push_back(exp_row(eff));
      cq_cyc.push_back(n + COLS + 2);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd) begin
        if (aq_addr.size() == 0) chk("unexpected_rd_addr", RW'(bus.mem_addr), '1);
        else begin
          chk("rd_addr", RW'(bus.mem_addr), RW'(aq_addr.pop_front()));
          chk("rd_cycle", RW'(cyc), RW'(aq_cyc.pop_front()));
        end
      end else chk("addr_idle", RW'(bus.mem_addr), '0);
      if (bus.rowReady) begin
        if (cq_row.size() == 0) chk("unexpected_rowReady", cur_row(), '1);
        else begin
          chk("commit_row", cur_row(), cq_row.pop_front());
          chk("commit_cycle", RW'(cyc), RW'(cq_cyc.pop_front()));
        end
      end
    end
  end
  initial begin
    int n;
    bus.LD_Row = 1'b0;
    bus.rowNum = '0;
    repeat (3) step();
    chk("rst_busy", RW'(bus.busy), '0);
    chk("rst_rowReady", RW'(bus.rowReady), '0);
    chk("rst_mem_rd", RW'(bus.mem_rd), '0);
    chk("rst_mem_addr", RW'(bus.mem_addr), '0);
    chk("rst_row", cur_row(), '0);
    rst = 1'b0;
    repeat (2) step();
    // Basic fetch of row 3.
    n = cyc;
    bus.rowNum = 8'd3;
    bus.LD_Row = 1'b1;
    expect_fetch(3, n, COLS);
    step();
    bus.LD_Row = 1'b0;
    chk("busy_in_read", RW'(bus.busy), RW'(1));
    repeat (15) step();
    chk("idle_after_commit", RW'(bus.busy), '0);
    // Second edge while busy is ignored.
    n = cyc;
    bus.LD_Row = 1'b1;
    expect_fetch(3, n, COLS);
    step();
    bus.LD_Row = 1'b0;
    repeat (4) step();
    bus.rowNum = 8'd7;
    bus.LD_Row = 1'b1;
    step();
    bus.LD_Row = 1'b0;
    repeat (12) step();
    // Level held high for 40 cycles starts exactly one fetch.
    n = cyc;
    bus.rowNum = 8'd0;
    bus.LD_Row = 1'b1;
    expect_fetch(0, n, COLS);
    repeat (40) step();
    bus.LD_Row = 1'b0;
    step();
    // Reset during a fetch aborts it.
    n = cyc;
    bus.rowNum = 8'd4;
    bus.LD_Row = 1'b1;
    expect_fetch(4, n, 5);
    step();
    bus.LD_Row = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", RW'(bus.busy), '0);
    chk("abort_row_zero", cur_row(), '0);
    step();
    n = cyc;
    bus.rowNum = 8'd2;
    bus.LD_Row = 1'b1;
    expect_fetch(2, n, COLS);
    step();
    bus.LD_Row = 1'b0;
    repeat (15) step();
    chk("abort_queue_drained", RW'(cq_row.size()), '0);
    // Out-of-range row.
    n = cyc;
    bus.rowNum = 8'd25;
    bus.LD_Row = 1'b1;
`ifdef BLANK_OOR_EN
    cq_row.push_back('0);
    cq_cyc.push_back(n + 1);
`else
    expect_fetch(25, n, COLS);
`endif
    step();
    bus.LD_Row = 1'b0;
    repeat (15) step();
    // Back-to-back edges at N and N+13.
    n = cyc;
    bus.rowNum = 8'd19;
    bus.LD_Row = 1'b1;
    expect_fetch(19, n, COLS);
    step();
    bus.LD_Row = 1'b0;
    repeat (12) step();
    bus.rowNum = 8'd0;
    bus.LD_Row = 1'b1;
    expect_fetch(0, n + 13, COLS);
    step();
    bus.LD_Row = 1'b0;
    repeat (15) step();
    // LD_Row held high through reset release counts as an edge.
    bus.rowNum = 8'd5;
    bus.LD_Row = 1'b1;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    n = cyc;
    expect_fetch(5, n, COLS);
    repeat (3) step();
    bus.LD_Row = 1'b0;
    repeat (14) step();
    chk("final_addr_queue", RW'(aq_addr.size()), '0);
    chk("final_commit_queue", RW'(cq_row.size()), '0);
    chk("final_busy", RW'(bus.busy), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/board_row_fetcher.md
BOARD_ROW_FETCHER -- requirements
Module: board_row_fetcher

Interface
REQ-001 SHALL have parameter BOARD_ROWS, default 20, meaning number of board rows.
REQ-002 SHALL have parameter BOARD_COLS, default 10, meaning cells per row and number of Row outputs.
REQ-003 SHALL have parameter CELL_W, default 16, meaning cell word width ({4'b0, R[3:0], G[3:0], B[3:0]}).
REQ-004 SHALL have parameter ADDR_W, default 8, meaning board memory address width.
REQ-005 SHALL have port Clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port LD_Row  input  1  row load request from the colour mapper.
REQ-008 SHALL have port rowNum  input  8  board row to fetch.
REQ-009 SHALL have port mem_addr  output  ADDR_W  board memory read address; cell address = row*BOARD_COLS + col.
REQ-010 SHALL have port mem_rd  output  1  board memory read strobe.
REQ-011 SHALL have port mem_rdata  input  CELL_W  board memory read data; valid the cycle after mem_rd.
REQ-012 SHALL have port Row  output  CELL_W x BOARD_COLS  unpacked array of the last committed row, Row[0] leftmost.
REQ-013 SHALL have port rowReady  output  1  one-cycle pulse on commit.
REQ-014 SHALL have port busy  output  1  high while a fetch is in progress.

Function
REQ-015 SHALL accept a request only on a rising edge of LD_Row (LD_Row high, previous-cycle LD_Row low) while in IDLE; a level held high across several cycles SHALL start exactly one fetch.
REQ-016 SHALL use states IDLE, READ, DRAIN, COMMIT; IDLE->READ on accept, READ->DRAIN after the issue for col BOARD_COLS-1, DRAIN->COMMIT, COMMIT->IDLE unconditionally.
REQ-017 On accept (cycle N) SHALL latch rowNum and compute base = rowNum*BOARD_COLS at ADDR_W width.
REQ-018 In READ SHALL assert mem_rd with mem_addr = base+col for cycles N+1..N+BOARD_COLS, col incrementing 0..BOARD_COLS-1, one address per cycle.
REQ-019 SHALL capture mem_rdata into shadow[col] one cycle after each issue (cycles N+2..N+BOARD_COLS+1).
REQ-020 In COMMIT (cycle N+BOARD_COLS+2, N+12 at default) SHALL copy all of shadow to Row in one cycle and assert rowReady for exactly that cycle.
REQ-021 Row SHALL change only at commit; partial fetches SHALL never be visible on Row.
REQ-022 SHALL assert busy in READ, DRAIN and COMMIT; busy low in IDLE.
REQ-023 SHALL ignore rising edges of LD_Row while busy; no queueing and no state disturbance.
REQ-024 mem_rd SHALL be low and mem_addr SHALL be 0 outside READ.
REQ-025 A rising edge in the cycle after COMMIT SHALL be accepted normally.

Reset
REQ-026 While reset is high: state=IDLE, Row all zero, shadow all zero, rowReady=0, busy=0, mem_rd=0, mem_addr=0, edge-detect history=0.
REQ-027 Reset asserted mid-fetch SHALL abort; no commit, no rowReady pulse, Row zero after reset.
REQ-028 LD_Row held high as reset deasserts SHALL count as a rising edge in the first cycle out of reset.

Configuration
REQ-029 Macro BLANK_OOR_EN defined: rowNum >= BOARD_ROWS SHALL skip READ/DRAIN, go IDLE->COMMIT, commit an all-zero Row with rowReady at cycle N+1, and issue no mem_rd.
REQ-030 Macro BLANK_OOR_EN undefined: rowNum >= BOARD_ROWS SHALL be clamped to BOARD_ROWS-1 and fetched normally with default latency.

Verification
REQ-031 Memory cell k preloaded with 16'h0100+k, LD_Row edge with rowNum=3 at cycle N -> mem_addr 30..39 on N+1..N+10, rowReady pulse at N+12, Row[i]=16'h011E+i.
REQ-032 LD_Row held high 40 cycles, rowNum=0 -> exactly one fetch, one rowReady pulse, addresses 0..9 once.
REQ-033 Second LD_Row edge at N+5 with rowNum=7 -> ignored; commit at N+12 holds row 3 data, no addresses 70..79 issued.
REQ-034 reset pulsed at N+6 of a fetch -> no rowReady, Row all zero, busy=0, next edge fetches correctly.
REQ-035 rowNum=25: with BLANK_OOR_EN -> rowReady at N+1, Row all zero, mem_rd never high; without -> addresses 190..199, commit at N+12.
REQ-036 Back-to-back edges at N and N+13 (rows 19 then 0) -> commits at N+12 and N+25 with correct data each.
